coeff_loader: RTL and testbench

- Sequences a new FIR coefficient set into the FIR datapath. It sits directly downstream of ahb_lite_slave.
- On new_coefficient_set it steps coefficient_num through F0..F(NUM_COEFFS-1) and pulses load_coeff once per coefficient to the FIR controller. It waits out each load using the modwait handshake.
- On completion it pulses coeff_clr back to the slave, which clears the new-coefficient-set flag.

---
 rtl/coeff_loader.sv | 121 ++++++++++++
 tb/tb_coeff_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_loader.sv
// ============================================================================
// coeff_loader: steps a new FIR coefficient set into the FIR controller,
// one load_coeff pulse per coefficient, paced by the modwait handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module coeff_loader #(
  parameter int unsigned NUM_COEFFS = 4,
  parameter int unsigned TIMEOUT    = 8,
  localparam int unsigned IDX_W     = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1,
  localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_coefficient_set,
  input  logic             modwait,
  output logic             load_coeff,
  output logic [IDX_W-1:0] coefficient_num,
  output logic             coeff_clr,
  output logic             loading,
  output logic             load_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFFS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             load_coeff_q;
  logic             coeff_clr_q;
  logic             loading_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (new_coefficient_set && !modwait) begin
          state_d = LOAD;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        // Counter ends at TIMEOUT on the last WAIT_HI cycle that may still see modwait.
        cnt_d = cnt_q + CNT_W'(1);
        if (modwait) begin
          state_d = WAIT_LO;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WAIT_LO: begin
        if (!modwait) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Pulse outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      load_coeff_q <= 1'b0;
      coeff_clr_q  <= 1'b0;
      loading_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      load_coeff_q <= (state_d == LOAD);
      coeff_clr_q  <= (state_d == DONE);
      loading_q    <= (state_d != IDLE);
    end
  end

  assign load_coeff      = load_coeff_q;
  assign coefficient_num = idx_q;
  assign coeff_clr       = coeff_clr_q;
  assign loading         = loading_q;
  assign load_err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_coeff_loader.sv
// ============================================================================
// tb_coeff_loader: scoreboard bench for coeff_loader with a small FIR model.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_coeff_loader;

  localparam int NUM_COEFFS = 4;
  localparam int TIMEOUT    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_coefficient_set;
  logic       modwait;
  logic       load_coeff;
  logic [1:0] coefficient_num;
  logic       coeff_clr;
  logic       loading;
  logic       load_err;

  logic fir_busy;
  logic busy_force;
  logic fir_respond;
  int   busy_len;

  assign modwait = fir_busy | busy_force;

  always #5 clk = ~clk;

  coeff_loader #(
    .NUM_COEFFS(NUM_COEFFS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .new_coefficient_set(new_coefficient_set),
    .modwait            (modwait),
    .load_coeff         (load_coeff),
    .coefficient_num    (coefficient_num),
    .coeff_clr          (coeff_clr),
    .loading            (loading),
    .load_err           (load_err)
  );

  typedef struct packed {
    logic       is_clr;
    logic [1:0] num;
    logic       err;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  loading_cycles = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push_loads(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{is_clr: 1'b0, num: 2'(i), err: 1'b0});
  endtask

  task automatic push_clr(input int num, input logic err);
    exp_q.push_back('{is_clr: 1'b1, num: 2'(num), err: err});
  endtask

  task automatic wait_pulse(input bit clr, input int max, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(posedge clk); #1;
      if (clr ? coeff_clr : load_coeff) seen = 1'b1;
    end
    if (!seen) check_eq(tag, 0, 1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  // Runs a nominal sequence with the slave clearing the flag after DONE.
  task automatic run_nominal(input string tag, input int exp_cycles);
    int start;
    push_loads(NUM_COEFFS);
    push_clr(NUM_COEFFS - 1, 1'b0);
    start = loading_cycles;
    new_coefficient_set = 1'b1;
    wait_pulse(1'b1, 200, {tag, "_clr_timeout"});
    @(posedge clk); #1;
    new_coefficient_set = 1'b0;
    wait_drain({tag, "_drain"});
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_err"}, 32'(load_err), 0);
    check_eq({tag, "_cycles"}, loading_cycles - start, exp_cycles);
  endtask

  // FIR model: raises modwait one cycle after each load_coeff for busy_len cycles.
  initial begin
    fir_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (load_coeff && fir_respond && !rst) begin
        @(posedge clk); #1;
        fir_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1;
        fir_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every pulse must match the head of the expected queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (loading) loading_cycles++;
        if (load_coeff || coeff_clr) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_pulse", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq("pulse_kind", 32'(coeff_clr), 32'(e.is_clr));
            check_eq("pulse_num", 32'(coefficient_num), 32'(e.num));
            check_eq("pulse_loading", 32'(loading), 1);
            check_eq("pulse_err", 32'(load_err), 32'(e.err));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1;
    new_coefficient_set = 1'b0;
    busy_force = 1'b0;
    fir_respond = 1'b1;
    busy_len = 3;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs",
             32'({load_coeff, coeff_clr, loading, load_err, coefficient_num}), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Nominal: 4 coefficients x (LOAD + WAIT_HI + 3 WAIT_LO) + DONE.
    run_nominal("nominal", 21);

    // Shortest handshake: modwait high one cycle per load gives 13 cycles.
    busy_len = 1;
    run_nominal("minimum", 13);
    busy_len = 3;

    // Busy at start: no load until modwait has fallen.
    push_loads(NUM_COEFFS);
    push_clr(NUM_COEFFS - 1, 1'b0);
    busy_force = 1'b1;
    new_coefficient_set = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check_eq("busy_noload", 32'(load_coeff), 0);
    end
    busy_force = 1'b0;
    @(posedge clk); #1;
    check_eq("busy_first_load", 32'(load_coeff), 1);
    check_eq("busy_first_num", 32'(coefficient_num), 0);
    wait_pulse(1'b1, 200, "busy_clr_timeout");
    @(posedge clk); #1;
    new_coefficient_set = 1'b0;
    wait_drain("busy_drain");

    // Timeout: FIR never responds.
    fir_respond = 1'b0;
    push_loads(1);
    push_clr(0, 1'b1);
    new_coefficient_set = 1'b1;
    wait_pulse(1'b0, 20, "to_load_timeout");
    cnt = 0;
    for (int i = 0; i < 30 && !coeff_clr; i++) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_eq("to_cycles", cnt, TIMEOUT + 1);
    @(posedge clk); #1;
    new_coefficient_set = 1'b0;
    wait_drain("to_drain");
    repeat (5) @(posedge clk);
    #1;
    check_eq("to_err_sticky", 32'(load_err), 1);
    check_eq("to_idle_loading", 32'(loading), 0);
    fir_respond = 1'b1;
    run_nominal("after_to", 21);

    // Flag dropped after the second load: sequence still completes.
    push_loads(NUM_COEFFS);
    push_clr(NUM_COEFFS - 1, 1'b0);
    new_coefficient_set = 1'b1;
    wait_pulse(1'b0, 20, "drop_load0_timeout");
    wait_pulse(1'b0, 20, "drop_load1_timeout");
    new_coefficient_set = 1'b0;
    wait_pulse(1'b1, 200, "drop_clr_timeout");
    wait_drain("drop_drain");
    repeat (10) @(posedge clk);
    #1;
    check_eq("drop_idle_loading", 32'(loading), 0);

    // Back-to-back: flag still high after DONE starts a second full set.
    push_loads(NUM_COEFFS);
    push_clr(NUM_COEFFS - 1, 1'b0);
    push_loads(NUM_COEFFS);
    push_clr(NUM_COEFFS - 1, 1'b0);
    new_coefficient_set = 1'b1;
    wait_pulse(1'b1, 200, "b2b_clr1_timeout");
    wait_pulse(1'b1, 200, "b2b_clr2_timeout");
    @(posedge clk); #1;
    new_coefficient_set = 1'b0;
    wait_drain("b2b_drain");

    // Asynchronous reset in WAIT_LO of coefficient 2.
    push_loads(3);
    new_coefficient_set = 1'b1;
    wait_pulse(1'b0, 20, "rst_load0_timeout");
    wait_pulse(1'b0, 20, "rst_load1_timeout");
    wait_pulse(1'b0, 20, "rst_load2_timeout");
    @(posedge clk);
    @(posedge clk);
    #2;
    check_eq("pre_rst_num", 32'(coefficient_num), 2);
    check_eq("pre_rst_modwait", 32'(modwait), 1);
    rst = 1'b1;
    #1;
    check_eq("rst_async_outputs",
             32'({load_coeff, coeff_clr, loading, load_err, coefficient_num}), 0);
    new_coefficient_set = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("post_rst_num", 32'(coefficient_num), 0);
    check_eq("post_rst_loading", 32'(loading), 0);
    check_eq("post_rst_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
